// File: rtl/uart_receiver.sv
// 8N1-style UART receive path sampling a 16x (OVERSAMPLE) baud tick.
// Recovers LSB-first frames, strobes rx_dv on good frames and frame_err on a low stop bit.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_out,
  output logic                  rx_dv,
  output logic                  frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                state, state_n;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n, rx_out_n;
  logic                  dv_n, fe_n;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state     <= IDLE;
      tcnt      <= '0;
      bcnt      <= '0;
      sh        <= '0;
      rx_out    <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      state     <= state_n;
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      sh        <= sh_n;
      rx_out    <= rx_out_n;
      rx_dv     <= dv_n;
      frame_err <= fe_n;
    end
  end

  // Counter clears at mid start bit, so every later wrap lands mid-bit.
  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    bcnt_n   = bcnt;
    sh_n     = sh;
    rx_out_n = rx_out;
    dv_n     = 1'b0;
    fe_n     = 1'b0;
    unique case (state)
      IDLE: if (!rx_s) begin
        tcnt_n  = '0;
        state_n = START;
      end
      START: if (tick) begin
        if (tcnt == T_MID) begin
          tcnt_n = '0;
          if (!rx_s) begin
            bcnt_n  = '0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt + T_ONE;
        end
      end
      DATA: if (tick) begin
        if (tcnt == T_END) begin
          tcnt_n = '0;
          sh_n   = {rx_s, sh[DATA_WIDTH-1:1]};
          if (bcnt == B_LAST) begin
            bcnt_n  = '0;
            state_n = STOP;
          end else begin
            bcnt_n = bcnt + B_ONE;
          end
        end else begin
          tcnt_n = tcnt + T_ONE;
        end
      end
      STOP: if (tick) begin
        if (tcnt == T_END) begin
          tcnt_n = '0;
          if (rx_s) begin
            rx_out_n = sh;
            dv_n     = 1'b1;
            state_n  = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end else begin
          tcnt_n = tcnt + T_ONE;
        end
      end
      // A held-low line must not retrigger; wait for it to return high.
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path, the counterpart to `transmitter`. It samples the serial line using the shared `baudrate_generator` tick, which runs at 16× oversampling (115200 baud from the 50 MHz `clk`). It recovers 8N1 frames, LSB first, and presents each received word with a one-cycle valid strobe. Stop-bit violations are reported with a one-cycle `frame_err` pulse.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 8.

Ports:
- `clk`  input  1: system clock, 50 MHz. One clock; all logic on its rising edge.
- `rst_n`  input  1: reset. Asynchronous assert, active-low.
- `tick`  input  1: one-`clk` pulse from `baudrate_generator`, OVERSAMPLE per bit period.
- `rx_in`  input  1: asynchronous serial line, idle high.
- `rx_out`  output  DATA_WIDTH: last correctly framed word. Held until the next good frame.
- `rx_dv`  output  1: one-`clk` pulse when `rx_out` is updated.
- `frame_err`  output  1: one-`clk` pulse when the stop bit samples low.

## Operation

- **Input synchronizer.** `rx_in` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1. All decisions use `rx_s`.
- **Counters.**
  - Tick counter `tcnt`: width clog2(OVERSAMPLE), advances only on `tick`.
  - Bit counter `bcnt`: counts 0..DATA_WIDTH-1.
  - Shift register `sh`: DATA_WIDTH bits. Each sampled bit shifts in at the MSB, right-shift, so the first bit received ends up at bit 0.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** on `rx_s==0`, clear `tcnt` and go to START. `tick` is not required for this transition.
  - **START:** on each `tick`, increment `tcnt`. On the tick where `tcnt==OVERSAMPLE/2-1` (mid start bit), check `rx_s`:
    - `rx_s==0`: clear `tcnt` and `bcnt`, go to DATA.
    - `rx_s==1`: glitch; go to IDLE with no output.
  - **DATA:** on each `tick`, increment `tcnt`. On the tick where `tcnt==OVERSAMPLE-1`:
    - clear `tcnt` and shift `rx_s` into `sh`;
    - if `bcnt==DATA_WIDTH-1`, clear `bcnt` and go to STOP;
    - else increment `bcnt`.
  - **STOP:** on the tick where `tcnt==OVERSAMPLE-1`, sample `rx_s`:
    - `rx_s==1`: `rx_out<=sh`, pulse `rx_dv`, go to IDLE.
    - `rx_s==0`: pulse `frame_err`, leave `rx_out` unchanged, go to BREAK.
  - **BREAK:** wait until `rx_s==1`, then go to IDLE. A held-low line therefore produces exactly one `frame_err` and never retriggers.
- **Timing of transitions.** The counter wrap at mid-start aligns every later sample to mid-bit. `tick` pulses are never missed or double-counted. Without `tick`, no state changes except IDLE→START and BREAK→IDLE.
- **Reset values**, applied asynchronously:
  - state = IDLE
  - `tcnt` = 0, `bcnt` = 0
  - `sh` = 0, `rx_out` = 0
  - `rx_dv` = 0, `frame_err` = 0
  - synchronizer flops = 1
- **Reset mid-frame** aborts the frame with no `rx_dv` and no `frame_err`. After `rst_n` releases, the block stays in IDLE until the next falling edge of `rx_s`.
- **Back-to-back frames.** A start bit may begin immediately after the stop-bit sample, i.e. half a bit early. The receiver must accept it; transitioning from STOP to IDLE on that tick guarantees this.

## Timing

- `rx_in` to `rx_s`: 2 `clk` latency.
- `rx_dv`/`frame_err` are registered. They rise on the `clk` edge following the mid-stop-bit `tick` cycle and stay high for exactly 1 `clk`.
- `rx_out` changes on the same edge `rx_dv` rises.
- Frame-end latency from the start-bit falling edge is (OVERSAMPLE/2 + (DATA_WIDTH+1)·OVERSAMPLE) ticks + 3 `clk`:
  - this is 152 ticks for the defaults;
  - at the 27-`clk` tick period this is about 82.1 µs.
- `rx_dv` and `frame_err` are never high in the same cycle.

## Test plan

- **Reset check:** assert `rst_n=0`, hold `rx_in=1`, release → `rx_out=8'h00`, `rx_dv=0`, `frame_err=0`. Neither strobe fires during 200 µs of idle.
- **Three spaced frames:** drive 0xA5, 0xF0, 0x3C, each 8N1 at 115200 baud, spaced 200 µs apart → exactly three `rx_dv` pulses, each 1 `clk` wide, with `rx_out`=A5, F0, 3C respectively.
- **Back-to-back frames:** drive 0x00 then 0xFF with no idle gap → two `rx_dv` pulses, `rx_out`=00 then FF, `frame_err` never high.
- **Glitch rejection:** pull `rx_in` low for 3 ticks (~1.6 µs), then high → no `rx_dv`, no `frame_err`, state returns to IDLE. A following 0x55 frame is received correctly.
- **Framing error:** send 0x3C with the stop bit low, then hold low for 3 bit times → one `frame_err` pulse, no `rx_dv`, `rx_out` keeps its prior value. After the line goes high, a 0x81 frame yields `rx_dv` with `rx_out=8'h81`.
- **Reset mid-frame:** pulse `rst_n` low during bit 4 of a 0xA5 frame → no strobes, `rx_out=8'h00`. The next complete 0xC3 frame is received correctly.
- **Loopback:** connect `transmitter.tx_out` to `rx_in`, both on the shared `tick`, and send 0xA5, 0xF0, 0x3C → `rx_out` matches each `tx_in` in order.
